serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder: accepts two operands plus a carry-in through a valid/ready handshake and adds them LSB-first, one bit per clock.
- Each bit is summed with a one-bit full-add cell built from two half adders; a carry flip-flop holds the carry between bits.
- It sits directly downstream of the half-adder primitive, consuming its sum/carry outputs.
- It gives the datapath a low-area multi-bit adder with a registered result.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands present on a_in/b_in/cin
- in_ready  output  1  block can accept operands
- a_in  input  WIDTH  operand A
- b_in  input  WIDTH  operand B
- cin  input  1  carry-in for bit 0
- out_valid  output  1  sum/cout valid
- out_ready  input  1  consumer accepts the result
- sum  output  WIDTH  A + B + cin, low WIDTH bits
- cout  output  1  carry out of bit WIDTH-1
- busy  output  1  high in RUN

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state = IDLE; a_sh, b_sh, sum_sh, carry and bit counter all = 0.
  - Outputs: in_ready = 1, out_valid = 0, sum = 0, cout = 0, busy = 0.
  - A reset during RUN or DONE aborts the operation; the partial result is discarded.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid = 1:
    - a_sh ← a_in, b_sh ← b_in, carry ← cin, cnt ← 0.
    - Go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - in_ready = 0, busy = 1.
  - Each edge, the full-add cell takes a_sh[0], b_sh[0] and carry:
    - s_bit = a^b^c; c_next = (a&b) | (c&(a^b)).
    - sum_sh ← {s_bit, sum_sh[WIDTH-1:1]}.
    - a_sh and b_sh shift right by 1.
    - carry ← c_next, cnt ← cnt+1.
  - On the edge where cnt == WIDTH-1: latch cout ← c_next and go to DONE.
- DONE:
  - out_valid = 1, in_ready = 0.
  - sum and cout are held stable until handshake completion.
  - On an edge with out_ready = 1: go to IDLE; out_valid drops the next cycle.
  - sum and cout keep their last value in IDLE; they are not cleared.
- Latency: accept at edge 0; out_valid is high after edge WIDTH, i.e. the result is visible WIDTH cycles after acceptance. Throughput is one operation per WIDTH+2 cycles minimum.
- in_valid while in_ready = 0 is ignored; a_in/b_in are not sampled.
- out_ready outside DONE is ignored.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid; both are decoded from registered state.
- Counter width is $clog2(WIDTH). cnt never exceeds WIDTH-1.
- Arithmetic is unsigned modulo 2^WIDTH, with cout as bit WIDTH. Overflow produces no flag other than cout.

Decomposition:
- Shared package serial_adder_pkg holds:
  - the state enum (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2);
  - the WIDTH bounds constants (MIN_WIDTH = 2, MAX_WIDTH = 32).
- One sub-module, fa_cell: a one-bit full add (a, b, ci → s, co) built from two half-adder instances plus an OR.
- The FSM, shift registers and counter live in serial_adder.

Test Plan:
- Reset then idle, WIDTH = 8: hold rst_n = 0 for 3 cycles, release → in_ready = 1, out_valid = 0, sum = 0x00, cout = 0, busy = 0.
- Basic add: a_in = 0x5A, b_in = 0x3C, cin = 0, out_ready = 1 → out_valid rises exactly 8 cycles after acceptance; sum = 0x96, cout = 0; back in IDLE one cycle later.
- Carry ripple and wrap: 0xFF + 0x01 cin = 0 → sum = 0x00, cout = 1. Then 0xFF + 0xFF cin = 1 → sum = 0xFF, cout = 1.
- Backpressure and ignored input:
  - Hold out_ready = 0 for 5 cycles in DONE → out_valid and sum held stable, in_ready = 0.
  - Toggle in_valid with new operands during RUN/DONE → result unchanged and no second acceptance.
  - Then out_ready = 1 → IDLE.
- Reset mid-operation: assert rst_n = 0 at cnt = 4 while adding 0x12 + 0x34 → outputs immediately reset values. After release, 0x01 + 0x01 yields sum = 0x02, cout = 0 with no residue.
- Back-to-back and randomized: 200 random operand/cin triples with random out_ready stalls at WIDTH = 8, 2 and 32 → each {cout, sum} equals a + b + cin, and latency is WIDTH cycles for every transaction.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  // Controller states of the serial adder.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Legal range of the WIDTH parameter.
  localparam int MIN_WIDTH = 32'd2;
  localparam int MAX_WIDTH = 32'd32;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit full-add cell composed from two half adders and an OR gate.

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p_s;
  logic g0_s;
  logic g1_s;

  // First stage: propagate/generate of the operand bits.
  half_adder u_ha0 (.a(a),   .b(b),  .s(p_s), .c(g0_s));
  // Second stage: fold in the incoming carry.
  half_adder u_ha1 (.a(p_s), .b(ci), .s(s),   .c(g1_s));

  assign co = g0_s | g1_s;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: loads A, B and carry-in through a valid/ready
// handshake, adds LSB-first one bit per clock and holds the registered
// result until the consumer accepts it.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("serial_adder: WIDTH out of supported range");
  end

  state_e           state_r;
  state_e           state_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] sum_sh_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             cout_r;
  logic [CNT_W-1:0] cnt_r;
  logic             s_bit_s;
  logic             c_next_s;
  logic             last_bit_s;

  // The single full-add cell always works on the current LSBs and carry.
  fa_cell u_fa (
    .a  (a_sh_r[0]),
    .b  (b_sh_r[0]),
    .ci (carry_r),
    .s  (s_bit_s),
    .co (c_next_s)
  );

  assign last_bit_s = (cnt_r == CNT_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_s = RUN;
        else          state_s = IDLE;
      end
      RUN: begin
        if (last_bit_s) state_s = DONE;
        else            state_s = RUN;
      end
      DONE: begin
        if (out_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Operand shifters, carry, bit counter and the held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r   <= '0;
      b_sh_r   <= '0;
      sum_sh_r <= '0;
      sum_r    <= '0;
      carry_r  <= 1'b0;
      cout_r   <= 1'b0;
      cnt_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_sh_r  <= a_in;
            b_sh_r  <= b_in;
            carry_r <= cin;
            cnt_r   <= '0;
          end
        end
        RUN: begin
          sum_sh_r <= {s_bit_s, sum_sh_r[WIDTH-1:1]};
          a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
          carry_r  <= c_next_s;
          if (last_bit_s) begin
            // Publish the finished word; the counter wraps so it never exceeds WIDTH-1.
            sum_r  <= {s_bit_s, sum_sh_r[WIDTH-1:1]};
            cout_r <= c_next_s;
            cnt_r  <= '0;
          end else begin
            cnt_r  <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Handshake flags decode only from the registered state.
  assign in_ready  = (state_r == IDLE);
  assign busy      = (state_r == RUN);
  assign out_valid = (state_r == DONE);
  assign sum       = sum_r;
  assign cout      = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH 8, 2 and 32.
module tb_serial_adder;

  typedef struct packed {
    logic [32:0] res;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  int   cycle = 0;
  int   checks = 0;
  int   failures = 0;

  logic        rst_n[3];
  logic        in_valid[3];
  logic        cin[3];
  logic        out_ready[3];
  logic [31:0] a_in[3];
  logic [31:0] b_in[3];
  logic        in_ready[3];
  logic        out_valid[3];
  logic        cout_w[3];
  logic        busy[3];
  logic [31:0] sum_w[3];
  exp_t        exp_q[3][$];
  logic        rnd_go = 1'b0;
  logic        rnd_done[3];

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cycle++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Present one operation; the expected result comes from plain integer arithmetic.
  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input int w);
    int n = 0;
    logic [63:0] m;
    logic [63:0] r;
    exp_t e;
    @(negedge clk);
    while (!in_ready[i] && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 64'(in_ready[i]), 64'd1);
    if (in_ready[i]) begin
      a_in[i] = a;
      b_in[i] = b;
      cin[i] = c;
      in_valid[i] = 1'b1;
      m = (64'd1 << w) - 64'd1;
      r = ({32'd0, a} & m) + ({32'd0, b} & m) + {63'd0, c};
      e.res = r[32:0];
      e.acc = cycle + 1;
      exp_q[i].push_back(e);
      @(negedge clk);
      in_valid[i] = 1'b0;
    end
  endtask

  task automatic wait_valid(input int i);
    int n = 0;
    while (!out_valid[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("valid_seen", 64'(out_valid[i]), 64'd1);
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while ((exp_q[i].size() != 0 || !in_ready[i]) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 64'(in_ready[i]), 64'd1);
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_w
    localparam int W = (gi == 0) ? 8 : ((gi == 1) ? 2 : 32);
    logic [W-1:0] sum_s;
    logic in_ready_s, out_valid_s, cout_s, busy_s;

    serial_adder #(.WIDTH(W)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[gi]),
      .in_valid  (in_valid[gi]),
      .in_ready  (in_ready_s),
      .a_in      (a_in[gi][W-1:0]),
      .b_in      (b_in[gi][W-1:0]),
      .cin       (cin[gi]),
      .out_valid (out_valid_s),
      .out_ready (out_ready[gi]),
      .sum       (sum_s),
      .cout      (cout_s),
      .busy      (busy_s)
    );

    assign sum_w[gi]     = 32'(sum_s);
    assign in_ready[gi]  = in_ready_s;
    assign out_valid[gi] = out_valid_s;
    assign cout_w[gi]    = cout_s;
    assign busy[gi]      = busy_s;

    // Monitor: pop on each new result, then watch that it stays put while stalled.
    initial begin
      logic prev_v;
      logic [W:0] held;
      exp_t e;
      prev_v = 1'b0;
      held = '0;
      forever begin
        @(negedge clk);
        if (!rst_n[gi]) begin
          prev_v = 1'b0;
        end else begin
          if (out_valid_s && !prev_v) begin
            if (exp_q[gi].size() == 0) begin
              check($sformatf("unexpected_result_w%0d", W), 64'({cout_s, sum_s}), 64'd0 - 64'd1);
            end else begin
              e = exp_q[gi].pop_front();
              check($sformatf("sum_cout_w%0d", W), 64'({cout_s, sum_s}), 64'(e.res[W:0]));
              check($sformatf("latency_w%0d", W), 64'(cycle - e.acc), 64'(W));
            end
            held = {cout_s, sum_s};
          end else if (out_valid_s) begin
            check($sformatf("hold_w%0d", W), 64'({cout_s, sum_s}), 64'(held));
            check($sformatf("ready_low_done_w%0d", W), 64'(in_ready_s), 64'd0);
          end
          prev_v = out_valid_s;
        end
      end
    end

    // Random traffic once the directed part is over.
    initial begin
      rnd_done[gi] = 1'b0;
      wait (rnd_go);
      for (int n = 0; n < 200; n++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        issue(gi, $urandom, $urandom, 1'($urandom_range(0, 1)), W);
      end
      rnd_done[gi] = 1'b1;
    end

    // Random consumer stalls during the random phase.
    initial begin
      wait (rnd_go);
      while (!rnd_done[gi]) begin
        @(negedge clk);
        out_ready[gi] = ($urandom_range(0, 3) != 0);
      end
      out_ready[gi] = 1'b1;
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0;
      in_valid[i] = 1'b0;
      cin[i] = 1'b0;
      out_ready[i] = 1'b0;
      a_in[i] = 32'd0;
      b_in[i] = 32'd0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready[0]), 64'd1);
    check("rst_out_valid", 64'(out_valid[0]), 64'd0);
    check("rst_sum", 64'(sum_w[0]), 64'd0);
    check("rst_cout", 64'(cout_w[0]), 64'd0);
    check("rst_busy", 64'(busy[0]), 64'd0);

    // Basic add, then IDLE one cycle after the handshake with the sum kept.
    out_ready[0] = 1'b1;
    issue(0, 32'h5A, 32'h3C, 1'b0, 8);
    check("run_busy", 64'(busy[0]), 64'd1);
    wait_valid(0);
    check("basic_sum", 64'(sum_w[0]), 64'h96);
    check("basic_cout", 64'(cout_w[0]), 64'd0);
    @(negedge clk);
    check("basic_valid_drop", 64'(out_valid[0]), 64'd0);
    check("basic_idle", 64'(in_ready[0]), 64'd1);
    check("basic_sum_kept", 64'(sum_w[0]), 64'h96);

    // Carry ripple and wrap.
    issue(0, 32'hFF, 32'h01, 1'b0, 8);
    wait_valid(0);
    check("wrap_sum", 64'(sum_w[0]), 64'h00);
    check("wrap_cout", 64'(cout_w[0]), 64'd1);
    issue(0, 32'hFF, 32'hFF, 1'b1, 8);
    wait_valid(0);
    check("max_sum", 64'(sum_w[0]), 64'hFF);
    check("max_cout", 64'(cout_w[0]), 64'd1);
    wait_idle(0);

    // Backpressure with junk operands offered while busy.
    out_ready[0] = 1'b0;
    issue(0, 32'h81, 32'h7F, 1'b1, 8);
    for (int k = 0; k < 3; k++) begin
      in_valid[0] = 1'b1;
      a_in[0] = $urandom;
      b_in[0] = $urandom;
      check("ready_low_run", 64'(in_ready[0]), 64'd0);
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    wait_valid(0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid[0] = ~in_valid[0];
      a_in[0] = $urandom;
      b_in[0] = $urandom;
      check("bp_valid", 64'(out_valid[0]), 64'd1);
      check("bp_ready", 64'(in_ready[0]), 64'd0);
      check("bp_sum", 64'(sum_w[0]), 64'h01);
      check("bp_cout", 64'(cout_w[0]), 64'd1);
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 64'(out_valid[0]), 64'd0);
    check("bp_release_ready", 64'(in_ready[0]), 64'd1);

    // Reset in the middle of an addition (counter at 4).
    issue(0, 32'h12, 32'h34, 1'b0, 8);
    repeat (4) @(negedge clk);
    rst_n[0] = 1'b0;
    exp_q[0].delete();
    #1;
    check("mid_rst_ready", 64'(in_ready[0]), 64'd1);
    check("mid_rst_valid", 64'(out_valid[0]), 64'd0);
    check("mid_rst_sum", 64'(sum_w[0]), 64'd0);
    check("mid_rst_cout", 64'(cout_w[0]), 64'd0);
    check("mid_rst_busy", 64'(busy[0]), 64'd0);
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1;
    issue(0, 32'h01, 32'h01, 1'b0, 8);
    wait_valid(0);
    check("post_rst_sum", 64'(sum_w[0]), 64'h02);
    check("post_rst_cout", 64'(cout_w[0]), 64'd0);
    wait_idle(0);

    // Random phase on all three widths at once.
    rnd_go = 1'b1;
    n = 0;
    while (!(rnd_done[0] && rnd_done[1] && rnd_done[2]) && n < 30000) begin
      @(negedge clk);
      n++;
    end
    check("random_phase_done", 64'(rnd_done[0] & rnd_done[1] & rnd_done[2]), 64'd1);
    for (int i = 0; i < 3; i++) begin
      wait_idle(i);
      check("queue_drained", 64'(exp_q[i].size()), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
